// File: rtl/stream_serializer.sv
// Stream serializer: accepts SIZE-bit words and emits them as RATIO beats of
// OUT_SIZE bits, least-significant beat first. A new word may be accepted on
// the same cycle the final beat of the current word transfers, so a
// continuous stream flows without idle bubbles.
module stream_serializer #(
  parameter int unsigned SIZE     = 8,
  parameter int unsigned OUT_SIZE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [SIZE-1:0]     in_data,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [OUT_SIZE-1:0] out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int unsigned RATIO = SIZE / OUT_SIZE;
  localparam int unsigned CntW  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(RATIO - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] data_q, data_d;

  logic accept;
  logic xfer;
  logic at_last;

  // Held word viewed as an array of beats; beat 0 is the LSB slice.
  logic [RATIO-1:0][OUT_SIZE-1:0] beats;
  assign beats = data_q;

  // Handshake and output decode.
  always_comb begin
    at_last  = (state_q == StSend) && (cnt_q == LastCnt);
    out_val  = (state_q == StSend);
    busy     = (state_q == StSend);
    out_last = at_last;
    out_data = beats[cnt_q];
    // Refill is only possible when the final beat leaves this very cycle.
    in_rdy   = (state_q == StIdle) || (at_last && out_rdy);
    accept   = in_val && in_rdy;
    xfer     = out_val && out_rdy;
  end

  // Next-state logic for the FSM, beat counter and word register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          if (!at_last) begin
            cnt_d = cnt_q + 1'b1;
          end else if (accept) begin
            data_d = in_data;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: doc/stream_serializer.md
STREAM_SERIALIZER -- requirements
Module: stream_serializer

Interface
REQ-001 The module SHALL have parameter SIZE, default 8, meaning the input word width in bits.
REQ-002 The module SHALL have parameter OUT_SIZE, default 2, meaning the output beat width in bits.
REQ-003 The module SHALL derive localparam RATIO = SIZE/OUT_SIZE; SIZE SHALL be an integer multiple of OUT_SIZE with RATIO >= 2.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_val  input  1  upstream word valid; this port connects to the FIFO pop side.
REQ-007 in_rdy  output  1  serializer can accept a word this cycle.
REQ-008 in_data  input  SIZE  upstream word; sampled only on in_val && in_rdy.
REQ-009 out_val  output  1  output beat valid.
REQ-010 out_rdy  input  1  downstream accepts a beat this cycle.
REQ-011 out_data  output  OUT_SIZE  current beat.
REQ-012 out_last  output  1  current beat is the final beat of its word.
REQ-013 busy  output  1  a word is held and is being serialized.

Function
REQ-014 The FSM SHALL have two states: IDLE (no word held) and SEND (word held in the data register, beat counter cnt in 0..RATIO-1).
REQ-015 A word accept SHALL occur when in_val && in_rdy.
REQ-016 A beat transfer SHALL occur when out_val && out_rdy.
REQ-017 in_rdy SHALL be 1 in IDLE, and 1 in SEND only when cnt == RATIO-1 && out_rdy; it SHALL be 0 otherwise. in_rdy depends combinationally on out_rdy.
REQ-018 Accept in IDLE SHALL latch in_data, set cnt=0 and move to SEND, independent of out_rdy.
REQ-019 out_val and busy SHALL equal (state == SEND).
REQ-020 out_data SHALL equal data bits [cnt*OUT_SIZE +: OUT_SIZE], sent LSB beat first.
REQ-021 out_last SHALL equal (state == SEND && cnt == RATIO-1).
REQ-022 A beat transfer with cnt < RATIO-1 SHALL increment cnt by 1.
REQ-023 A beat transfer with cnt == RATIO-1 and a simultaneous accept SHALL load the new word, set cnt=0 and stay in SEND, with no idle bubble.
REQ-024 A beat transfer with cnt == RATIO-1 and no accept SHALL return the FSM to IDLE.
REQ-025 While out_val && !out_rdy, out_data, out_last, cnt and the held word SHALL remain stable.
REQ-026 The first beat of an accepted word SHALL appear on out_data the cycle after the accept (latency 1).
REQ-027 With out_rdy held at 1 and in_val held at 1, throughput SHALL be 1 word per RATIO cycles and 1 beat per cycle.
REQ-028 Words SHALL be neither dropped nor duplicated; output beat order SHALL equal input word order.
REQ-029 in_data SHALL be ignored when no accept occurs.

Reset
REQ-030 While rst_n = 0, the FSM SHALL be in IDLE with cnt = 0 and the data register = 0.
REQ-031 While rst_n = 0, out_val = 0, out_last = 0, busy = 0, out_data = 0 and in_rdy = 1.
REQ-032 Reset asserted mid-word SHALL discard the held word and remaining beats immediately (asynchronous); no beats of that word SHALL appear after reset.
REQ-033 After reset release, the next accepted word SHALL serialize starting at beat 0.

Verification (SIZE=8, OUT_SIZE=2)
REQ-034 Single word: push 0xB4 with out_rdy=1 -> out_data 0,1,3,2 on 4 consecutive cycles; out_last only on the 4th; in_rdy=0 during beats 1-3.
REQ-035 Back-to-back: in_val held, words 0xB4 then 0x1E, out_rdy=1 -> 8 consecutive beats 0,1,3,2,2,3,1,0; second accept coincides with the first word's out_last.
REQ-036 Backpressure: out_rdy=0 for 3 cycles at beat index 1 of 0xB4 -> out_data holds 1 and out_last holds 0; the sequence then resumes 3,2.
REQ-037 Idle accept under stall: in_val=1 and out_rdy=0 in IDLE -> word accepted; out_val=1 with beat 0 held; in_rdy=0 until the last beat transfers.
REQ-038 Reset mid-word: rst_n low after 2 beats of 0xB4 -> out_val=0 and in_rdy=1 at once; after release, push 0x1E -> 2,3,1,0.
REQ-039 Random test: random in_val and out_rdy over 10k cycles -> a scoreboard of reassembled words matches the input words exactly.
